// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with a double-buffered digit load port.
// Define SEG7_SCAN_LZB_EN to enable leading-zero blanking of the upper digit slots.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 10000,
    parameter int BLANK_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic [3:0]              seg_bcd,
    input  logic [6:0]              seg_in,
    output logic [6:0]              segments,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_tick
);
    localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : {CW{1'b0}};
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHOW  = 2'd1;
    localparam logic [1:0] ST_BLANK = 2'd2;

    logic [1:0]              state_r, state_nx_s;
    logic [IW-1:0]           idx_r, idx_nx_s, idx_inc_s;
    logic [CW-1:0]           cnt_r, cnt_nx_s;
    logic [4*NUM_DIGITS-1:0] active_r, pending_r;
    logic                    pend_full_r;
    logic                    commit_s, wrap_s, lit_s;
    logic [3:0]              seg_bcd_s;
    logic [NUM_DIGITS-1:0]   onehot_s;
    logic [6:0]              segments_r;
    logic [NUM_DIGITS-1:0]   digit_en_r;
    logic                    frame_tick_r;

    assign load_ready = ~pend_full_r;
    assign seg_bcd    = seg_bcd_s;
    assign segments   = segments_r;
    assign digit_en   = digit_en_r;
    assign frame_tick = frame_tick_r;

    assign wrap_s    = (idx_r == IDX_LAST);
    assign idx_inc_s = wrap_s ? {IW{1'b0}} : idx_r + IW'(1);

    // Shared-decoder nibble select and one-hot digit enable for the current slot
    always_comb begin
        seg_bcd_s = 4'h0;
        onehot_s  = {NUM_DIGITS{1'b0}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            onehot_s[i] = (idx_r == IW'(i));
            seg_bcd_s   = (idx_r == IW'(i)) ? active_r[i*4 +: 4] : seg_bcd_s;
        end
    end

`ifdef SEG7_SCAN_LZB_EN
    logic [IW-1:0] msd_s;

    // Slots above the most significant nonzero nibble stay dark; slot 0 always lights
    always_comb begin
        msd_s = {IW{1'b0}};
        for (int i = 1; i < NUM_DIGITS; i++) begin
            msd_s = (active_r[i*4 +: 4] != 4'h0) ? IW'(i) : msd_s;
        end
        lit_s = (idx_r <= msd_s);
    end
`else
    assign lit_s = 1'b1;
`endif

    // Scan sequencing; dropping enable returns to IDLE from any state
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        cnt_nx_s   = cnt_r;
        commit_s   = 1'b0;
        if (!enable) begin
            state_nx_s = ST_IDLE;
            idx_nx_s   = {IW{1'b0}};
            cnt_nx_s   = {CW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nx_s = ST_SHOW;
                    idx_nx_s   = {IW{1'b0}};
                    cnt_nx_s   = {CW{1'b0}};
                end
                ST_SHOW: begin
                    if (cnt_r == SCAN_LAST) begin
                        cnt_nx_s = {CW{1'b0}};
                        if (BLANK_CYCLES > 0) begin
                            state_nx_s = ST_BLANK;
                        end else begin
                            idx_nx_s = idx_inc_s;
                            commit_s = wrap_s & pend_full_r;
                        end
                    end else begin
                        cnt_nx_s = cnt_r + CW'(1);
                    end
                end
                ST_BLANK: begin
                    if (cnt_r == BLANK_LAST) begin
                        state_nx_s = ST_SHOW;
                        cnt_nx_s   = {CW{1'b0}};
                        idx_nx_s   = idx_inc_s;
                        commit_s   = wrap_s & pend_full_r;
                    end else begin
                        cnt_nx_s = cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                    idx_nx_s   = {IW{1'b0}};
                    cnt_nx_s   = {CW{1'b0}};
                end
            endcase
        end
        commit_s = commit_s | ((state_r == ST_IDLE) & pend_full_r);
    end

    // FSM state, slot index and cycle counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            idx_r   <= {IW{1'b0}};
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_nx_s;
            idx_r   <= idx_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Double buffer: frames only switch at slot-0 entry or while idle, so they never tear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_r    <= {(4*NUM_DIGITS){1'b0}};
            pending_r   <= {(4*NUM_DIGITS){1'b0}};
            pend_full_r <= 1'b0;
        end else if (commit_s) begin
            active_r    <= pending_r;
            pend_full_r <= 1'b0;
        end else if (load_valid && !pend_full_r) begin
            pending_r   <= load_data;
            pend_full_r <= 1'b1;
        end else begin
            pend_full_r <= pend_full_r;
        end
    end

    // Registered pad drive, one cycle behind the scan state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            segments_r   <= 7'd0;
            digit_en_r   <= {NUM_DIGITS{1'b0}};
            frame_tick_r <= 1'b0;
        end else begin
            if ((state_r == ST_SHOW) && lit_s) begin
                segments_r <= seg_in;
                digit_en_r <= onehot_s;
            end else begin
                segments_r <= 7'd0;
                digit_en_r <= {NUM_DIGITS{1'b0}};
            end
            frame_tick_r <= (state_r == ST_SHOW) && (idx_r == {IW{1'b0}}) && (cnt_r == {CW{1'b0}});
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: directed scenarios plus random stimulus
// compared every cycle against a frame-position reference model.
module tb_seg7_scan_ctrl;
    localparam int N     = 4;
    localparam int SD    = 4;
    localparam int BC    = 1;
    localparam int P     = SD + BC;
    localparam int FRAME = N * P;

    logic           clk = 1'b0;
    logic           reset;
    logic           enable;
    logic           load_valid;
    logic           load_ready;
    logic [4*N-1:0] load_data;
    logic [3:0]     seg_bcd;
    logic [6:0]     seg_in;
    logic [6:0]     segments;
    logic [N-1:0]   digit_en;
    logic           frame_tick;

    logic [6:0] seg_lut [16];
    assign seg_in = seg_lut[seg_bcd];

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .NUM_DIGITS   (N),
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .seg_bcd    (seg_bcd),
        .seg_in     (seg_in),
        .segments   (segments),
        .digit_en   (digit_en),
        .frame_tick (frame_tick)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model: scan position as cycles since the scan started
    bit             m_running;
    int             m_t;
    logic [4*N-1:0] m_active;
    logic [4*N-1:0] m_pending;
    bit             m_pend_full;
    logic [6:0]     exp_segments;
    logic [N-1:0]   exp_digit_en;
    logic           exp_frame_tick;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] nib(input logic [4*N-1:0] b, input int k);
        return b[k*4 +: 4];
    endfunction

    function automatic int msd(input logic [4*N-1:0] b);
        int r = 0;
        for (int k = 1; k < N; k++) begin
            if (nib(b, k) != 4'h0) r = k;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_running      = 1'b0;
        m_t            = 0;
        m_active       = '0;
        m_pending      = '0;
        m_pend_full    = 1'b0;
        exp_segments   = 7'd0;
        exp_digit_en   = '0;
        exp_frame_tick = 1'b0;
    endtask

    // called just after a falling edge: check, drive, advance model, wait for next falling edge
    task automatic step(input logic en, input logic lv, input logic [4*N-1:0] data);
        int         slot;
        int         phase;
        bit         showing;
        logic [3:0] cur_nib;
        slot    = (m_t / P) % N;
        phase   = m_t % P;
        cur_nib = m_running ? nib(m_active, slot) : nib(m_active, 0);
        check_eq("seg_bcd", seg_bcd, cur_nib);
        check_eq("load_ready", load_ready, !m_pend_full);
        check_eq("segments", segments, exp_segments);
        check_eq("digit_en", digit_en, exp_digit_en);
        check_eq("frame_tick", frame_tick, exp_frame_tick);

        enable     = en;
        load_valid = lv;
        load_data  = data;

        showing = m_running && (phase < SD);
`ifdef SEG7_SCAN_LZB_EN
        showing = showing && (slot <= msd(m_active));
`endif
        exp_digit_en   = showing ? (N'(1) << slot) : '0;
        exp_segments   = showing ? seg_lut[cur_nib] : 7'd0;
        exp_frame_tick = m_running && ((m_t % FRAME) == 0);

        if (m_pend_full && (!m_running || (en && ((m_t + 1) % FRAME == 0)))) begin
            m_active    = m_pending;
            m_pend_full = 1'b0;
        end else if (lv && !m_pend_full) begin
            m_pending   = data;
            m_pend_full = 1'b1;
        end

        if (!en) begin
            m_running = 1'b0;
            m_t       = 0;
        end else if (!m_running) begin
            m_running = 1'b1;
            m_t       = 0;
        end else begin
            m_t++;
        end
        @(negedge clk);
    endtask

    // reset pulse placed between clock edges; outputs must clear without a clock
    task automatic async_reset_check();
        #2 reset = 1'b1;
        #1;
        check_eq("rst_segments", segments, 7'd0);
        check_eq("rst_digit_en", digit_en, '0);
        check_eq("rst_frame_tick", frame_tick, 1'b0);
        check_eq("rst_load_ready", load_ready, 1'b1);
        check_eq("rst_seg_bcd", seg_bcd, 4'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) seg_lut[i] = 7'($urandom) | 7'h01;
        reset      = 1'b1;
        enable     = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // basic frame with 0x1234, then a mid-frame load and a rejected second load
        step(1'b0, 1'b1, 16'h1234);
        for (int i = 0; i < 40 && !(m_running && m_t == 6); i++) step(1'b1, 1'b0, 16'h0000);
        step(1'b1, 1'b1, 16'h5678);
        step(1'b1, 1'b1, 16'h9999);
        repeat (45) step(1'b1, 1'b0, 16'h0000);

        // async reset while a digit is lit
        for (int i = 0; i < 10 && !(m_running && (m_t % P) < SD); i++) step(1'b1, 1'b0, 16'h0000);
        async_reset_check();
        repeat (25) step(1'b1, 1'b0, 16'h0000);

        // enable dropped during blanking with a pending value
        async_reset_check();
        step(1'b0, 1'b1, 16'hABCD);
        step(1'b1, 1'b0, 16'h0000);
        step(1'b1, 1'b1, 16'h0F0E);
        for (int i = 0; i < 20 && !(m_running && (m_t % P) == SD); i++) step(1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);
        repeat (25) step(1'b1, 1'b0, 16'h0000);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                async_reset_check();
            end else begin
                step(($urandom_range(0, 99) != 0), ($urandom_range(0, 7) == 0), 16'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
